// File: rtl/tod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tod_counter_if
//  Description : Time-load channel of the time-of-day counter. The requester
//                presents hh:mm:ss with set_valid; the counter answers with
//                set_ready and a one-cycle set_err when the value is rejected.
//  Ports       : set_valid  requester -> counter, load request
//                set_hour   requester -> counter, hour 0-23
//                set_min    requester -> counter, minute 0-59
//                set_sec    requester -> counter, second 0-59
//                set_ready  counter -> requester, load can be accepted
//                set_err    counter -> requester, rejected-load pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface tod_counter_if;
   logic       set_valid;
   logic       set_ready;
   logic [4:0] set_hour;
   logic [5:0] set_min;
   logic [5:0] set_sec;
   logic       set_err;

   // Requester side
   modport master (
      output set_valid,
      output set_hour,
      output set_min,
      output set_sec,
      input  set_ready,
      input  set_err
   );

   // Counter side
   modport slave (
      input  set_valid,
      input  set_hour,
      input  set_min,
      input  set_sec,
      output set_ready,
      output set_err
   );
endinterface
`default_nettype wire

// File: rtl/tod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tod_counter
//  Description : 24-hour time-of-day counter advanced by a 1 Hz tick, with a
//                validated time-load channel, a midnight pulse and an alarm
//                state machine (IDLE / RINGING / optional SNOOZED).
//  Build macro : TOD_SNOOZE_EN - when defined, snooze while ringing parks the
//                alarm in SNOOZED for 300 ticks; when undefined the snooze
//                input is ignored and the SNOOZED state is not built.
//  Ports       : clk        system clock
//                rst        synchronous active-high reset
//                tick       one-cycle 1 Hz seconds pulse
//                set_bus    time-load channel (tod_counter_if.slave)
//                alm_hour   alarm hour
//                alm_min    alarm minute
//                alm_en     alarm armed
//                alm_ack    stop ringing
//                snooze     snooze request
//                hour       current hour 0-23
//                min        current minute 0-59
//                sec        current second 0-59
//                day_pulse  one-cycle pulse on the midnight wrap
//                ring       alarm sounding
//  Revision    : 1.0 - initial release
// ============================================================================
module tod_counter (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       tick,
   tod_counter_if.slave    set_bus,
   input  wire logic [4:0] alm_hour,
   input  wire logic [5:0] alm_min,
   input  wire logic       alm_en,
   input  wire logic       alm_ack,
   input  wire logic       snooze,
   output logic      [4:0] hour,
   output logic      [5:0] min,
   output logic      [5:0] sec,
   output logic            day_pulse,
   output logic            ring
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [4:0] HOUR_MAX      = 5'd23;
   localparam logic [5:0] MINSEC_MAX    = 6'd59;
   localparam logic [8:0] RING_TICKS_M1 = 9'd59;   // last tick of a 60-tick ring
`ifdef TOD_SNOOZE_EN
   localparam logic [8:0] SNZ_TICKS_M1  = 9'd299;  // last tick of a 300-tick snooze
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1
`ifdef TOD_SNOOZE_EN
      ,
      ST_SNOOZED = 2'd2
`endif
   } state_t;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   logic [4:0] hour_q,      hour_d;
   logic [5:0] min_q,       min_d;
   logic [5:0] sec_q,       sec_d;
   logic       day_pulse_q, day_pulse_d;
   logic       set_err_q,   set_err_d;
   logic       busy_q,      busy_d;      // set on the cycle after an accepted load
   state_t     state_q,     state_d;
   logic [8:0] cnt_q,       cnt_d;       // ticks seen since entering the current state

   // -------------------------------------------------------------------------
   // Load handshake and effective tick
   // -------------------------------------------------------------------------
   logic load_accept;
   logic load_in_range;
   logic tick_eff;
   logic alarm_hit;

   assign load_accept   = set_bus.set_valid & ~busy_q;
   assign load_in_range = (set_bus.set_hour <= HOUR_MAX)   &&
                          (set_bus.set_min  <= MINSEC_MAX) &&
                          (set_bus.set_sec  <= MINSEC_MAX);
   // An accepted load (valid or rejected) swallows a coincident tick, for the
   // time base and for the alarm timers alike.
   assign tick_eff      = tick & ~load_accept;

`ifndef TOD_SNOOZE_EN
   logic unused_snooze;
   assign unused_snooze = snooze;
`endif

   // -------------------------------------------------------------------------
   // Time base next state
   // -------------------------------------------------------------------------
   always_comb begin
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      day_pulse_d = 1'b0;
      set_err_d   = load_accept & ~load_in_range;
      busy_d      = load_accept;

      if (load_accept) begin
         if (load_in_range) begin
            hour_d = set_bus.set_hour;
            min_d  = set_bus.set_min;
            sec_d  = set_bus.set_sec;
         end
      end else if (tick_eff) begin
         if (sec_q == MINSEC_MAX) begin
            sec_d = 6'd0;
            if (min_q == MINSEC_MAX) begin
               min_d = 6'd0;
               if (hour_q == HOUR_MAX) begin
                  hour_d      = 5'd0;
                  day_pulse_d = 1'b1;
               end else begin
                  hour_d = hour_q + 5'd1;
               end
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end
   end

   // Only a counting tick can arm the alarm; a load landing on hh:mm:00 never
   // does because tick_eff is low whenever a load is accepted.
   assign alarm_hit = tick_eff & alm_en &
                      (hour_d == alm_hour) & (min_d == alm_min) & (sec_d == 6'd0);

   // -------------------------------------------------------------------------
   // Alarm state machine - next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (alarm_hit) begin
               state_d = ST_RINGING;
            end
         end

         ST_RINGING: begin
            // Acknowledge outranks snooze when both arrive together.
            if (alm_ack || !alm_en) begin
               state_d = ST_IDLE;
`ifdef TOD_SNOOZE_EN
            end else if (snooze) begin
               state_d = ST_SNOOZED;
`endif
            end else if (tick_eff && (cnt_q == RING_TICKS_M1)) begin
               state_d = ST_IDLE;
            end
         end

`ifdef TOD_SNOOZE_EN
         ST_SNOOZED: begin
            if (alm_ack || !alm_en) begin
               state_d = ST_IDLE;
            end else if (tick_eff && (cnt_q == SNZ_TICKS_M1)) begin
               state_d = ST_RINGING;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Counter restarts from zero on every state entry.
      if (state_d != state_q) begin
         cnt_d = 9'd0;
      end else if (tick_eff) begin
         cnt_d = cnt_q + 9'd1;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         hour_q      <= 5'd0;
         min_q       <= 6'd0;
         sec_q       <= 6'd0;
         day_pulse_q <= 1'b0;
         set_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= 9'd0;
      end else begin
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         day_pulse_q <= day_pulse_d;
         set_err_q   <= set_err_d;
         busy_q      <= busy_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign hour              = hour_q;
   assign min               = min_q;
   assign sec               = sec_q;
   assign day_pulse         = day_pulse_q;
   assign ring              = (state_q == ST_RINGING);
   assign set_bus.set_ready = ~busy_q;
   assign set_bus.set_err   = set_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tod_counter
//  Description : Self-checking bench for tod_counter: a table of directed
//                vectors, hand-written alarm timeout / snooze sequences, and
//                a randomized run compared against a seconds-of-day model.
//  Build macro : TOD_SNOOZE_EN selects the expected snooze behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tod_counter;

`ifdef TOD_SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [4:0] alm_hour;
   logic [5:0] alm_min;
   logic       alm_en;
   logic       alm_ack;
   logic       snooze;
   logic [4:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic       day_pulse;
   logic       ring;

   tod_counter_if bus ();

   tod_counter dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .set_bus   (bus.slave),
      .alm_hour  (alm_hour),
      .alm_min   (alm_min),
      .alm_en    (alm_en),
      .alm_ack   (alm_ack),
      .snooze    (snooze),
      .hour      (hour),
      .min       (min),
      .sec       (sec),
      .day_pulse (day_pulse),
      .ring      (ring)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------------------------------------------------------- model
   // Time is held as seconds since midnight; alarm as a named mode plus the
   // number of ticks seen since that mode began.
   int m_secs  = 0;
   int m_mode  = 0;     // 0 idle, 1 ringing, 2 snoozed
   int m_ticks = 0;
   bit m_busy  = 1'b0;
   bit m_err   = 1'b0;
   bit m_dp    = 1'b0;

   function automatic int hms(input int h, input int m, input int s);
      return h * 3600 + m * 60 + s;
   endfunction

   task automatic model_update();
      bit acc, ok, te, hit;
      if (rst) begin
         m_secs = 0; m_mode = 0; m_ticks = 0;
         m_busy = 0; m_err = 0; m_dp = 0;
      end else begin
         acc = bus.set_valid && !m_busy;
         ok  = (int'(bus.set_hour) < 24) && (int'(bus.set_min) < 60) && (int'(bus.set_sec) < 60);
         te  = tick && !acc;
         m_err  = acc && !ok;
         m_dp   = 0;
         m_busy = acc;
         if (acc) begin
            if (ok) m_secs = hms(int'(bus.set_hour), int'(bus.set_min), int'(bus.set_sec));
         end else if (te) begin
            m_secs = (m_secs + 1) % 86400;
            m_dp   = (m_secs == 0);
         end
         hit = te && alm_en && (m_secs / 3600 == int'(alm_hour)) &&
               ((m_secs / 60) % 60 == int'(alm_min)) && (m_secs % 60 == 0);
         case (m_mode)
            0: if (hit) begin m_mode = 1; m_ticks = 0; end
            1: begin
               if (alm_ack || !alm_en) m_mode = 0;
               else if (SNZ && snooze) begin m_mode = 2; m_ticks = 0; end
               else if (te) begin
                  m_ticks++;
                  if (m_ticks == 60) m_mode = 0;
               end
            end
            default: begin
               if (alm_ack || !alm_en) m_mode = 0;
               else if (te) begin
                  m_ticks++;
                  if (m_ticks == 300) begin m_mode = 1; m_ticks = 0; end
               end
            end
         endcase
      end
   endtask

   // ---------------------------------------------------------------- helpers
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      rst = 0; tick = 0; alm_ack = 0; snooze = 0;
      bus.set_valid = 0;
   endtask

   task automatic load(input int h, input int m, input int s);
      bus.set_valid = 1;
      bus.set_hour  = 5'(h);
      bus.set_min   = 6'(m);
      bus.set_sec   = 6'(s);
      step();
      bus.set_valid = 0;
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      bit rst; bit tick; bit vld; int h; int m; int s;
      bit en; int ah; int am; bit ack; bit snz;
      int eh; int em; int es; bit edp; bit ering; bit erdy; bit eerr;
   } vec_t;

   vec_t vecs[19];

   initial begin
      int t;
      bit exp_ring;

      clear_inputs();
      rst = 1;
      alm_hour = 0; alm_min = 0; alm_en = 0;
      bus.set_hour = 0; bus.set_min = 0; bus.set_sec = 0;

      //         rst tk vl  h   m   s  en ah am ack snz   eh  em  es dp rg rdy err
      vecs[0]  = '{1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,    0,  0,  0, 0, 0, 1, 0};
      vecs[1]  = '{0, 0, 1, 23, 59, 59, 0, 0, 0, 0, 0,   23, 59, 59, 0, 0, 0, 0};
      vecs[2]  = '{0, 1, 0,  0,  0,  0, 0, 0, 0, 0, 0,    0,  0,  0, 1, 0, 1, 0};
      vecs[3]  = '{0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,    0,  0,  0, 0, 0, 1, 0};
      vecs[4]  = '{0, 0, 1, 12, 60,  0, 0, 0, 0, 0, 0,    0,  0,  0, 0, 0, 0, 1};
      vecs[5]  = '{0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,    0,  0,  0, 0, 0, 1, 0};
      vecs[6]  = '{0, 1, 1,  7, 15, 30, 0, 0, 0, 0, 0,    7, 15, 30, 0, 0, 0, 0};
      vecs[7]  = '{0, 1, 1,  1,  1,  1, 0, 0, 0, 0, 0,    7, 15, 31, 0, 0, 1, 0};
      vecs[8]  = '{0, 0, 1,  6, 29, 59, 1, 6,30, 0, 0,    6, 29, 59, 0, 0, 0, 0};
      vecs[9]  = '{0, 1, 0,  0,  0,  0, 1, 6,30, 0, 0,    6, 30,  0, 0, 1, 1, 0};
      vecs[10] = '{0, 0, 0,  0,  0,  0, 1, 6,30, 1, 0,    6, 30,  0, 0, 0, 1, 0};
      vecs[11] = '{0, 1, 0,  0,  0,  0, 1, 6,30, 0, 0,    6, 30,  1, 0, 0, 1, 0};
      vecs[12] = '{0, 0, 1,  6, 30,  0, 1, 6,30, 0, 0,    6, 30,  0, 0, 0, 0, 0};
      vecs[13] = '{0, 0, 0,  0,  0,  0, 1, 6,30, 0, 0,    6, 30,  0, 0, 0, 1, 0};
      vecs[14] = '{1, 1, 1,  5,  5,  5, 1, 6,30, 0, 0,    0,  0,  0, 0, 0, 1, 0};
      vecs[15] = '{0, 0, 1, 23, 24, 60, 0, 0, 0, 0, 0,    0,  0,  0, 0, 0, 0, 1};
      vecs[16] = '{0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,    0,  0,  0, 0, 0, 1, 0};
      vecs[17] = '{0, 0, 1, 24,  0,  0, 0, 0, 0, 0, 0,    0,  0,  0, 0, 0, 0, 1};
      vecs[18] = '{0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,    0,  0,  0, 0, 0, 1, 0};

      #2;
      for (int i = 0; i < 19; i++) begin
         rst           = vecs[i].rst;
         tick          = vecs[i].tick;
         bus.set_valid = vecs[i].vld;
         bus.set_hour  = 5'(vecs[i].h);
         bus.set_min   = 6'(vecs[i].m);
         bus.set_sec   = 6'(vecs[i].s);
         alm_en        = vecs[i].en;
         alm_hour      = 5'(vecs[i].ah);
         alm_min       = 6'(vecs[i].am);
         alm_ack       = vecs[i].ack;
         snooze        = vecs[i].snz;
         step();
         chk($sformatf("v%0d.hour", i),      int'(hour),              vecs[i].eh);
         chk($sformatf("v%0d.min", i),       int'(min),               vecs[i].em);
         chk($sformatf("v%0d.sec", i),       int'(sec),               vecs[i].es);
         chk($sformatf("v%0d.day_pulse", i), int'(day_pulse),         int'(vecs[i].edp));
         chk($sformatf("v%0d.ring", i),      int'(ring),              int'(vecs[i].ering));
         chk($sformatf("v%0d.set_ready", i), int'(bus.set_ready),     int'(vecs[i].erdy));
         chk($sformatf("v%0d.set_err", i),   int'(bus.set_err),       int'(vecs[i].eerr));
      end
      clear_inputs();

      // ------------------------------------------- ring timeout after 60 ticks
      alm_en = 1; alm_hour = 10; alm_min = 0;
      load(9, 59, 59);
      step();
      tick = 1; step(); tick = 0;
      chk("timeout.ring_on", int'(ring), 1);
      chk("timeout.min_on", int'(min), 0);
      for (int i = 1; i <= 60; i++) begin
         tick = 1; step();
         chk($sformatf("timeout.ring_t%0d", i), int'(ring), (i < 60) ? 1 : 0);
      end
      chk("timeout.min_end", int'(min), 1);
      chk("timeout.sec_end", int'(sec), 0);
      step();
      chk("timeout.ring_stays_off", int'(ring), 0);
      tick = 0;

      // ------------------------------------------- snooze
      load(9, 59, 59);
      step();
      tick = 1; step(); tick = 0;
      chk("snooze.ring_on", int'(ring), 1);
      snooze = 1; step(); snooze = 0;
      chk("snooze.ring_after_snooze", int'(ring), SNZ ? 0 : 1);
      for (int i = 1; i <= 300; i++) begin
         tick = 1; step();
         exp_ring = SNZ ? (i == 300) : (i < 60);
         chk($sformatf("snooze.ring_t%0d", i), int'(ring), int'(exp_ring));
      end
      tick = 0;
      alm_ack = 1; snooze = 1; step(); alm_ack = 0; snooze = 0;
      chk("ack_snooze.ring_off", int'(ring), 0);
      for (int i = 1; i <= 300; i++) begin
         tick = 1; step();
      end
      tick = 0;
      chk("ack_snooze.stays_idle", int'(ring), 0);

      // ------------------------------------------- disarm while ringing
      load(9, 59, 59);
      step();
      tick = 1; step(); tick = 0;
      chk("disarm.ring_on", int'(ring), 1);
      alm_en = 0; step();
      chk("disarm.ring_off", int'(ring), 0);
      alm_en = 1;

      // ------------------------------------------- randomized vs model
      for (int c = 0; c < 6000; c++) begin
         rst  = ($urandom_range(0, 799) == 0);
         tick = $urandom_range(0, 1);
         if ($urandom_range(0, 399) == 0) begin
            alm_hour = 5'($urandom_range(0, 23));
            alm_min  = 6'($urandom_range(0, 59));
         end
         alm_en        = ($urandom_range(0, 399) != 0);
         alm_ack       = ($urandom_range(0, 499) == 0);
         snooze        = ($urandom_range(0, 79) == 0);
         bus.set_valid = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) != 0) begin
            t = (hms(int'(alm_hour), int'(alm_min), 0) - int'($urandom_range(1, 3)) + 86400) % 86400;
            bus.set_hour = 5'(t / 3600);
            bus.set_min  = 6'((t / 60) % 60);
            bus.set_sec  = 6'(t % 60);
         end else begin
            bus.set_hour = 5'($urandom_range(0, 31));
            bus.set_min  = 6'($urandom_range(0, 63));
            bus.set_sec  = 6'($urandom_range(0, 63));
         end
         step();
         chk($sformatf("rnd%0d.hour", c),      int'(hour),          m_secs / 3600);
         chk($sformatf("rnd%0d.min", c),       int'(min),           (m_secs / 60) % 60);
         chk($sformatf("rnd%0d.sec", c),       int'(sec),           m_secs % 60);
         chk($sformatf("rnd%0d.day_pulse", c), int'(day_pulse),     int'(m_dp));
         chk($sformatf("rnd%0d.ring", c),      int'(ring),          (m_mode == 1) ? 1 : 0);
         chk($sformatf("rnd%0d.set_ready", c), int'(bus.set_ready), int'(!m_busy));
         chk($sformatf("rnd%0d.set_err", c),   int'(bus.set_err),   int'(m_err));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tod_counter.md
TOD_COUNTER -- requirements
Module: tod_counter

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: reset; synchronous and active-high, one clock (clk).
- tick, in, 1: one-cycle 1 Hz seconds pulse from the seconds prescaler.
- set_valid, in, 1: time-load request.
- set_ready, out, 1: load can be accepted.
- set_hour, in, 5: load hour value.
- set_min, in, 6: load minute value.
- set_sec, in, 6: load second value.
- set_err, out, 1: one-cycle pulse; load was rejected.
- alm_hour, in, 5: alarm hour.
- alm_min, in, 6: alarm minute.
- alm_en, in, 1: alarm armed.
- alm_ack, in, 1: stops ringing.
- snooze, in, 1: snooze request.
- hour, out, 5: current hour, binary 0-23.
- min, out, 6: current minute, binary 0-59.
- sec, out, 6: current second, binary 0-59.
- day_pulse, out, 1: one-cycle pulse on the midnight wrap.
- ring, out, 1: alarm sounding.

Function
REQ-002 On each cycle with tick=1, sec SHALL increment by one, with the update visible on the next cycle.
- Wrap rule: sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0.
REQ-003 The tick that moves 23:59:59 to 00:00:00 SHALL assert day_pulse for exactly one cycle, coincident with the 00:00:00 output.
REQ-004 set_ready SHALL be 1 in all states except the single cycle following an accepted load.
REQ-005 A load SHALL be accepted when set_valid=1 and set_ready=1.
REQ-006 An accepted load with all values in range SHALL update hour/min/sec on the next cycle.
REQ-007 An accepted load with hour>23, min>59 or sec>59 SHALL leave the time unchanged and pulse set_err for one cycle.
REQ-008 If tick and an accepted load occur in the same cycle, the load SHALL win and the tick SHALL be discarded.
REQ-009 Alarm state machine SHALL have states IDLE, RINGING and SNOOZED.
REQ-010 IDLE->RINGING SHALL occur on a tick that produces hour==alm_hour, min==alm_min, sec==0 while alm_en=1.
REQ-011 A load SHALL never trigger the alarm, even if the loaded time matches.
REQ-012 ring SHALL be 1 only in RINGING.
REQ-013 RINGING->IDLE SHALL occur on alm_ack=1, on alm_en=0, or after 60 ticks counted in RINGING, whichever comes first.
REQ-014 alm_ack and snooze asserted in the same cycle SHALL resolve as alm_ack (go to IDLE).
REQ-015 SNOOZED->RINGING SHALL occur after 300 ticks; SNOOZED->IDLE SHALL occur on alm_ack=1 or alm_en=0.
REQ-016 Time counting SHALL continue unaffected in every alarm state.
REQ-017 An internal tick counter SHALL be 9 bits, SHALL clear on every state entry, and SHALL advance only on tick.

Reset
REQ-018 While rst=1 at a clk edge: hour/min/sec SHALL become 0, the state SHALL become IDLE, and ring=0, day_pulse=0, set_err=0, set_ready=1, tick counter=0.
REQ-019 rst SHALL override tick, a pending load, and alarm activity in the same cycle; a load requested in that cycle SHALL be lost.

Configuration
REQ-020 Macro TOD_SNOOZE_EN SHALL control snooze.
- Defined: snooze=1 in RINGING moves to SNOOZED (REQ-015).
- Undefined: snooze is ignored, the SNOOZED state does not exist, and RINGING exits only per REQ-013.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load 23:59:59 then one tick -> 00:00:00 and day_pulse=1 for one cycle.
- Load 12:60:00 -> set_err pulse; time unchanged.
- Load 07:15:30 with tick in the same cycle -> 07:15:30, not 07:15:31.
- alm_en=1, alarm 06:30, load 06:29:59, one tick -> ring=1; alm_ack -> ring=0 next cycle.
- Ringing with no ack for 60 ticks -> ring=0 and state IDLE.
- TOD_SNOOZE_EN defined: snooze while ringing -> ring=0; after 300 ticks -> ring=1. Undefined: snooze has no effect.
